// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and round helper functions.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] H_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word sliding message schedule window; w[0] is always the current Wt.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block,
  output logic [31:0]  wt
);

  logic [31:0] w [0:15];
  logic [31:0] w_next;

  // W[t+16] from the window positions holding W[t+14], W[t+9], W[t+1], W[t]
  always_comb begin
    w_next = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0];
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int unsigned i = 0; i < 16; i++) begin
        w[i] <= block[511 - 32*i -: 32];
      end
    end else if (shift) begin
      for (int unsigned i = 0; i < 15; i++) begin
        w[i] <= w[i+1];
      end
      w[15] <= w_next;
    end
  end

  assign wt = w[0];

endmodule

// File: rtl/sha256_core.sv
// Iterative single-block SHA-256 compression: one round per clock, start/ready handshake.
module sha256_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] message_block,
  input  logic         start,
  output logic [255:0] hash_out,
  output logic         ready
);

  state_e      state;
  logic [5:0]  t;
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] wt, t1, t2;
  logic        accept;

  assign ready  = (state == IDLE);
  assign accept = ready && start;

  sha256_msg_sched u_sched (
    .clk   (clk),
    .load  (accept),
    .shift (state == ROUND),
    .block (message_block),
    .wt    (wt)
  );

  always_comb begin
    t1 = h + Sigma1(e) + ch(e, f, g) + K[t] + wt;
    t2 = Sigma0(a) + maj(a, b, c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      t        <= '0;
      hash_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            {a, b, c, d} <= {H_INIT[0], H_INIT[1], H_INIT[2], H_INIT[3]};
            {e, f, g, h} <= {H_INIT[4], H_INIT[5], H_INIT[6], H_INIT[7]};
            t            <= '0;
            state        <= ROUND;
          end
        end
        ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          t <= t + 6'd1;
          if (t == 6'd63) state <= FINAL;
        end
        FINAL: begin
          hash_out <= {H_INIT[0] + a, H_INIT[1] + b, H_INIT[2] + c, H_INIT[3] + d,
                       H_INIT[4] + e, H_INIT[5] + f, H_INIT[6] + g, H_INIT[7] + h};
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_core.sv
// Directed known-answer bench for sha256_core: digests, latency, handshake and reset abort.
module tb_sha256_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] message_block;
  logic         start;
  logic [255:0] hash_out;
  logic         ready;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [511:0] blk_empty, blk_abc, blk_hello, blk_test;
  logic [255:0] dig_empty, dig_abc, dig_hello, dig_test;

  always #5 clk = ~clk;

  sha256_core dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .message_block (message_block),
    .start         (start),
    .hash_out      (hash_out),
    .ready         (ready)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // hold: leave start high afterwards; disturb: re-pulse start with a different block mid-run
  task automatic run_hash(input string tag, input logic [511:0] blk, input logic [255:0] exp,
                          input bit hold, input bit disturb, input logic [255:0] prev);
    int cycles = 0;
    @(negedge clk);
    message_block = blk;
    start         = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy"}, {255'd0, ready}, 256'd0);
    check({tag, "_keep"}, hash_out, prev);
    if (!hold) start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (disturb && n == 10) begin
        start         = 1'b1;
        message_block = blk_hello;
      end
      if (disturb && n == 12) start = 1'b0;
      @(posedge clk); #1;
      if (ready) begin
        cycles = n;
        break;
      end
    end
    check({tag, "_latency"}, 256'(cycles), 256'd65);
    check({tag, "_digest"}, hash_out, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    blk_empty = {32'h80000000, 480'h0};
    blk_abc   = {32'h61626380, 448'h0, 32'h00000018};
    blk_hello = {32'h68656c6c, 32'h6f800000, 416'h0, 32'h00000028};
    blk_test  = {32'h74657374, 32'h80000000, 416'h0, 32'h00000020};
    dig_empty = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    dig_abc   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    dig_hello = 256'h2cf24dba5fb0a30e26e83b2ac5b9e29e1b161e5c1fa7425e73043362938b9824;
    dig_test  = 256'h9f86d081884c7d659a2feaa0c55ad015a3bf4f1b2b0b822cd15d6c15b0f00a08;

    rst_n         = 1'b0;
    start         = 1'b0;
    message_block = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {255'd0, ready}, 256'd1);
    check("reset_hash", hash_out, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_hash("empty", blk_empty, dig_empty, 1'b0, 1'b0, 256'd0);
    run_hash("abc",   blk_abc,   dig_abc,   1'b0, 1'b0, dig_empty);
    run_hash("hello", blk_hello, dig_hello, 1'b0, 1'b0, dig_abc);
    run_hash("test",  blk_test,  dig_test,  1'b0, 1'b0, dig_hello);

    run_hash("b2b_first",  blk_abc, dig_abc, 1'b1, 1'b0, dig_test);
    run_hash("b2b_second", blk_abc, dig_abc, 1'b0, 1'b0, dig_abc);

    run_hash("disturb", blk_abc, dig_abc, 1'b0, 1'b1, dig_abc);
    @(negedge clk);
    message_block = blk_test;
    repeat (3) @(posedge clk);
    #1;
    check("ignored_start_idle", {255'd0, ready}, 256'd1);
    check("ignored_start_hash", hash_out, dig_abc);

    // abort during round 30: rounds 0..29 occupy the 30 edges after accept
    @(negedge clk);
    message_block = blk_abc;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("abort_still_busy", {255'd0, ready}, 256'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", {255'd0, ready}, 256'd1);
    check("abort_hash", hash_out, 256'd0);
    rst_n = 1'b1;

    run_hash("after_abort", blk_abc, dig_abc, 1'b0, 1'b0, 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
